// File: rtl/chain_index_gen.sv
// chain_index_gen
// Walks the matrix-chain DP table in span order and emits one (i, j, k)
// read tuple per accepted cycle. On the last split of a cell it also raises
// rw with the cell's write address (iw, jw). An optional diagonal pass writes
// every (i, i) cell before the span walk.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a walk (honoured only in IDLE)
//   matlen            chain length n, captured on an accepted start
//   init_diag         prefix the walk with the diagonal pass
//   ready             downstream accepts the current tuple
//   valid             ir/jr/kr/rw/iw/jw hold a tuple
//   ir, jr, kr        read row, column, split
//   rw, iw, jw        write strobe and write cell address
//   busy              walk in progress (INIT or RUN)
//   done              one-cycle pulse after the last tuple is accepted
//
// state | meaning
// IDLE  | waiting for start
// INIT  | diagonal pass, tuple (i,i,i) with write
// RUN   | span walk d=1..n-1, i=0..n-1-d, k=i..j-1
// DONE  | done pulse, back to IDLE next cycle
module chain_index_gen #(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] matlen,
  input  logic             init_diag,
  input  logic             ready,
  output logic             valid,
  output logic [IDX_W-1:0] ir,
  output logic [IDX_W-1:0] jr,
  output logic [IDX_W-1:0] kr,
  output logic             rw,
  output logic [IDX_W-1:0] iw,
  output logic [IDX_W-1:0] jw,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] TWO = IDX_W'(2);

  state_t           state;
  logic [IDX_W-1:0] n;
  logic [IDX_W-1:0] n_m1;
  logic [IDX_W-1:0] span;
  logic [IDX_W-1:0] k_next;
  logic             last_k;

  // j is never 0 in RUN, so jr-1 cannot wrap while it matters.
  assign n_m1   = n - ONE;
  assign span   = jr - ir;
  assign k_next = kr + ONE;
  assign last_k = (kr == (jr - ONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n     <= '0;
      valid <= 1'b0;
      rw    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ir    <= '0;
      jr    <= '0;
      kr    <= '0;
      iw    <= '0;
      jw    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            n  <= matlen;
            ir <= '0;
            kr <= '0;
            iw <= '0;
            if (init_diag && (matlen != '0)) begin
              state <= INIT;
              valid <= 1'b1;
              busy  <= 1'b1;
              rw    <= 1'b1;
              jr    <= '0;
              jw    <= '0;
            end else if (matlen >= TWO) begin
              state <= RUN;
              valid <= 1'b1;
              busy  <= 1'b1;
              rw    <= 1'b1;
              jr    <= ONE;
              jw    <= ONE;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        INIT: begin
          if (ready) begin
            if (ir != n_m1) begin
              ir <= ir + ONE;
              jr <= ir + ONE;
              kr <= ir + ONE;
              iw <= ir + ONE;
              jw <= ir + ONE;
            end else if (n >= TWO) begin
              // First span-1 cell follows immediately, no bubble.
              state <= RUN;
              ir    <= '0;
              jr    <= ONE;
              kr    <= '0;
              rw    <= 1'b1;
              iw    <= '0;
              jw    <= ONE;
            end else begin
              state <= DONE;
              valid <= 1'b0;
              busy  <= 1'b0;
              rw    <= 1'b0;
              done  <= 1'b1;
            end
          end
        end

        RUN: begin
          if (ready) begin
            if (!last_k) begin
              kr <= k_next;
              if (k_next == (jr - ONE)) begin
                rw <= 1'b1;
                iw <= ir;
                jw <= jr;
              end else begin
                rw <= 1'b0;
              end
            end else if (jr != n_m1) begin
              // Next cell in the same span; a span-1 cell has a single split.
              ir <= ir + ONE;
              jr <= jr + ONE;
              kr <= ir + ONE;
              if (span == ONE) begin
                rw <= 1'b1;
                iw <= ir + ONE;
                jw <= jr + ONE;
              end else begin
                rw <= 1'b0;
              end
            end else if (ir == '0) begin
              state <= DONE;
              valid <= 1'b0;
              busy  <= 1'b0;
              rw    <= 1'b0;
              done  <= 1'b1;
            end else begin
              // Span d finished: restart at row 0 of span d+1 (d+1 >= 2).
              ir <= '0;
              jr <= span + ONE;
              kr <= '0;
              rw <= 1'b0;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
